// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter with send/busy handshake and retry
// Optional feature macro: UART_TX_FIFO_DROP_CNT_EN enables the saturating dropped-write counter.
`timescale 1ns/1ps

module uart_tx_fifo #(
    parameter int DEPTH         = 16,
    parameter int START_TIMEOUT = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [7:0]               i_wr_data,
    input  logic                     i_wr_en,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_send,
    input  logic                     i_tx_busy,
    output logic                     o_idle,
    output logic [7:0]               o_drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(START_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_START,
        ST_WAIT_DONE
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr_next;
    logic [AW:0]   rd_ptr_next;
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] tmo_cnt;
    logic [CW-1:0] tmo_cnt_next;
    logic          wr_accept;
    logic          pop;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign wr_accept   = i_wr_en && !o_full;
    assign wr_ptr_next = wr_accept ? wr_ptr + 1'b1 : wr_ptr;
    assign rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;

    // Byte storage; no reset needed, validity is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem[wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    // Pointers and registered occupancy flags; pointer MSB separates full from empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            o_level <= wr_ptr_next - rd_ptr_next;
            o_empty <= (wr_ptr_next == rd_ptr_next);
            o_full  <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                       (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
        end
    end

    // Next-state logic: pop in IDLE, pulse in SEND, retry if busy never rises.
    always_comb begin
        state_next   = state;
        tmo_cnt_next = tmo_cnt;
        pop          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!o_empty && !i_tx_busy) begin
                    pop        = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                state_next   = ST_WAIT_START;
                tmo_cnt_next = '0;
            end
            ST_WAIT_START: begin
                if (i_tx_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (tmo_cnt == CNT_LAST) begin
                    state_next = ST_SEND;
                end else begin
                    tmo_cnt_next = tmo_cnt + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register and registered transmitter-side outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            o_tx_send <= 1'b0;
            o_tx_data <= 8'h00;
            o_idle    <= 1'b1;
        end else begin
            state     <= state_next;
            tmo_cnt   <= tmo_cnt_next;
            o_tx_send <= (state_next == ST_SEND);
            if (pop) begin
                o_tx_data <= mem[rd_ptr[AW-1:0]];
            end
            o_idle    <= (wr_ptr_next == rd_ptr_next) && (state_next == ST_IDLE);
        end
    end

`ifdef UART_TX_FIFO_DROP_CNT_EN
    // Saturating count of writes refused because the FIFO was full.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_drop_cnt <= 8'h00;
        end else if (i_wr_en && o_full && (o_drop_cnt != 8'hFF)) begin
            o_drop_cnt <= o_drop_cnt + 8'h01;
        end
    end
`else
    assign o_drop_cnt = 8'h00;
`endif

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-wide transmit buffer that sits directly upstream of the UART top level and feeds its transmitter. A producer pushes bytes at up to one per clock; the block stores them in a power-of-two FIFO and drains them one at a time. For each byte it presents the byte on `o_tx_data`, pulses `o_tx_send`, and tracks the transmitter's busy flag so each byte is sent exactly once. Overflow is reported, never silently blocked.

## Interface
Parameters:
- `DEPTH` — 16 — FIFO depth in bytes; power of two, ≥2. `AW = $clog2(DEPTH)` is derived.
- `START_TIMEOUT` — 16 — cycles to wait for `i_tx_busy` to rise after a send pulse before re-pulsing; ≥2.

Ports (one clock; reset is synchronous and active-high):
- `i_clk` — in — 1 — clock.
- `i_rst` — in — 1 — synchronous active-high reset.
- `i_wr_data` — in — 8 — byte to enqueue.
- `i_wr_en` — in — 1 — enqueue strobe; one byte per cycle.
- `o_full` — out — 1 — FIFO holds `DEPTH` bytes.
- `o_empty` — out — 1 — FIFO holds 0 bytes.
- `o_level` — out — AW+1 — current occupancy.
- `o_tx_data` — out — 8 — byte to transmitter (UART `data_in`).
- `o_tx_send` — out — 1 — one-cycle send request (UART `send_data`).
- `i_tx_busy` — in — 1 — transmitter busy (UART `o_transmission`).
- `o_idle` — out — 1 — FIFO empty and FSM in IDLE.
- `o_drop_cnt` — out — 8 — saturating count of dropped writes.

## Operation
- **Storage:** `DEPTH`×8 array with AW+1-bit read and write pointers. The MSB distinguishes full from empty, and pointers wrap modulo 2·DEPTH.
- **Write:** accepted when `i_wr_en=1` and `o_full=0`, using the pre-edge `o_full`.
  - A write while full is dropped. This holds even if a pop happens in the same cycle.
  - `o_drop_cnt` increments on each drop and saturates at 255.
- **FSM states:** IDLE, SEND, WAIT_START, WAIT_DONE.
  - **IDLE:** if `o_empty=0` and `i_tx_busy=0`, pop the head into `o_tx_data` and go to SEND.
  - **SEND:** `o_tx_send=1` for this one cycle, then go to WAIT_START and clear the timeout counter.
  - **WAIT_START:** if `i_tx_busy=1`, go to WAIT_DONE. Otherwise increment the counter; when it reaches `START_TIMEOUT-1`, go back to SEND with the same byte (retry).
  - **WAIT_DONE:** when `i_tx_busy=0`, go to IDLE.
- **Simultaneous write and pop:** both take effect and `o_level` is unchanged. A pop uses the pre-edge `o_empty`, so a write into an empty FIFO is not popped in the same cycle.
- **Outputs:** `o_tx_send`, `o_tx_data`, `o_full`, `o_empty`, `o_level` and `o_idle` are all registered.

## Timing
- **Reset values:** `o_full=0`, `o_empty=1`, `o_level=0`, `o_tx_data=8'h00`, `o_tx_send=0`, `o_idle=1`, `o_drop_cnt=0`; state IDLE; pointers and timeout counter 0.
- **Latency:** a write sampled at edge k into an empty, idle block gives:
  - `o_empty=0` after edge k;
  - pop at edge k+1, with `o_tx_data` valid from k+1;
  - `o_tx_send` high from edge k+1 to edge k+2.
- **Data hold:** `o_tx_data` holds its value from the pop until the next pop, including across retries.
- **Retry:** with `i_tx_busy` stuck low, `o_tx_send` pulses every `START_TIMEOUT+1` cycles.
- **Back-to-back bytes:** the next pop occurs at the first edge where the FSM is in IDLE with `i_tx_busy=0`. Minimum inter-byte overhead is 2 cycles after busy falls.
- **Reset mid-operation:** the FIFO is flushed and the current byte abandoned. The transmitter is not aborted. After reset, IDLE will not pop until `i_tx_busy=0`.

## Configuration
- **`UART_TX_FIFO_DROP_CNT_EN` defined:** `o_drop_cnt` counts dropped writes as described above.
- **Not defined:** the counter logic is removed and `o_drop_cnt` is tied to 8'h00. Overflow behaviour (drop on full) is identical.

## Test plan
- **Reset:** assert `i_rst` 3 cycles with random inputs → every output equals its reset value, and `o_tx_send` never pulses.
- **Single byte:** write 8'hA5 at edge k; model asserts busy 2 cycles after the send pulse, for 10 cycles → exactly one `o_tx_send` pulse (k+1..k+2), `o_tx_data=8'hA5`, `o_idle=1` 2 cycles after busy falls.
- **Overflow:** hold `i_tx_busy=1` and write 17 bytes 8'h00..8'h10 at DEPTH=16 → `o_full=1` after 16 writes, `o_level=16`, 8'h10 dropped, `o_drop_cnt=1` (0 with the macro off). Then release busy → bytes 8'h00..8'h0F emitted in order, one pulse each.
- **Timeout retry:** write 8'h3C, never assert busy, START_TIMEOUT=4 → `o_tx_send` pulses every 5 cycles with `o_tx_data=8'h3C`, and `o_level` stays 0.
- **Reset mid-run:** level 5 with busy high, then pulse `i_rst` → `o_level=0`, `o_empty=1`, and no `o_tx_send` after busy falls until a new write.
- **Loopback:** connect to the UART top level, 50 MHz, 115200 baud; write "HELLO" (8'h48,45,4C,4C,4F) → the receiver reports 5 `data_rdy` pulses with `data_out` matching in order, and `o_drop_cnt=0`.
